// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key command scheduler: per-key FSM states,
// timer sizing helper, and cycle constants for 50 MHz silicon and fast simulation.
package key_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } key_fsm_e;

    localparam int LONG_PRESS_CYC_50M = 25_000_000;
    localparam int REPEAT_CYC_50M     = 5_000_000;
    localparam int LONG_PRESS_CYC_SIM = 10;
    localparam int REPEAT_CYC_SIM     = 4;

    // Timer must hold max(long, repeat) - 1; never narrower than one bit.
    function automatic int timer_width(input int long_cyc, input int rep_cyc);
        int m;
        m = (long_cyc > rep_cyc) ? long_cyc : rep_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Per-key press/hold FSM: pulses set_pend on the press event and on each auto-repeat
// tick (set_rep marks repeats). Pulses are combinational from the current cycle; no backpressure.
module key_hold_timer
    import key_sched_pkg::*;
#(
    parameter int LONG_PRESS_CYC = LONG_PRESS_CYC_50M,
    parameter int REPEAT_CYC     = REPEAT_CYC_50M
) (
    input  logic Clk,
    input  logic Rst,
    input  logic press_evt,
    input  logic release_evt,
    output logic set_pend,
    output logic set_rep
);

    localparam int TW = timer_width(LONG_PRESS_CYC, REPEAT_CYC);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_PRESS_CYC - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

    key_fsm_e      state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Release takes priority over a timer expiry landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        set_pend = 1'b0;
        set_rep  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (press_evt) begin
                    set_pend = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (release_evt) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == LONG_LAST) begin
                    set_pend = 1'b1;
                    set_rep  = 1'b1;
                    timer_d  = '0;
                    state_d  = REPEAT;
                end
            end
            REPEAT: begin
                if (release_evt) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == REP_LAST) begin
                    set_pend = 1'b1;
                    set_rep  = 1'b1;
                    timer_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Key events -> serialized valid/ready command stream, round-robin across keys; press-to-valid 2 cycles,
// one-deep pending per key holds work under backpressure. KEY_SCHED_DROP_CNT_EN adds the drop_cnt output.
module key_cmd_scheduler
    import key_sched_pkg::*;
#(
    parameter int  NUM_KEYS       = 2,
    parameter int  LONG_PRESS_CYC = LONG_PRESS_CYC_50M,
    parameter int  REPEAT_CYC     = REPEAT_CYC_50M,
    localparam int IDW            = $clog2(NUM_KEYS)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_state,
    output logic                cmd_valid,
    output logic [IDW-1:0]      cmd_id,
    output logic                cmd_repeat,
    input  logic                cmd_ready
`ifdef KEY_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);

    logic [NUM_KEYS-1:0] set_pend, set_rep;
    logic [NUM_KEYS-1:0] pend_q, pend_d, rep_q, rep_d;
    logic [NUM_KEYS-1:0] grant_clr, drop_vec;
    logic [IDW-1:0]      rr_q, rr_d, cmd_id_q, cmd_id_d, idx;
    logic                cmd_valid_q, cmd_valid_d, cmd_repeat_q, cmd_repeat_d;
    logic                can_issue, found;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_hold_timer #(
            .LONG_PRESS_CYC (LONG_PRESS_CYC),
            .REPEAT_CYC     (REPEAT_CYC)
        ) u_timer (
            .Clk         (Clk),
            .Rst         (Rst),
            .press_evt   (key_flag[i] & ~key_state[i]),
            .release_evt (key_flag[i] &  key_state[i]),
            .set_pend    (set_pend[i]),
            .set_rep     (set_rep[i])
        );
    end

    // Output slot reloads when empty or being accepted, so cmd_ready high gives one command per cycle.
    always_comb begin
        can_issue    = ~cmd_valid_q | cmd_ready;
        found        = 1'b0;
        idx          = '0;
        grant_clr    = '0;
        cmd_valid_d  = cmd_valid_q & ~cmd_ready;
        cmd_id_d     = cmd_id_q;
        cmd_repeat_d = cmd_repeat_q;
        rr_d         = rr_q;
        if (can_issue) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                idx = IDW'((int'(rr_q) + k) % NUM_KEYS);
                if (!found && pend_q[idx]) begin
                    found          = 1'b1;
                    grant_clr[idx] = 1'b1;
                    cmd_valid_d    = 1'b1;
                    cmd_id_d       = idx;
                    cmd_repeat_d   = rep_q[idx];
                    rr_d           = IDW'((int'(idx) + 1) % NUM_KEYS);
                end
            end
        end
    end

    // A new set beats a same-cycle grant; a set onto a still-held pend is dropped and keeps the old rep.
    always_comb begin
        drop_vec = set_pend & pend_q & ~grant_clr;
        pend_d   = (pend_q & ~grant_clr) | set_pend;
        rep_d    = rep_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (set_pend[i] && !drop_vec[i]) begin
                rep_d[i] = set_rep[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pend_q       <= '0;
            rep_q        <= '0;
            rr_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= '0;
            cmd_repeat_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            rep_q        <= rep_d;
            rr_q         <= rr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_id_q     <= cmd_id_d;
            cmd_repeat_q <= cmd_repeat_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_id     = cmd_id_q;
    assign cmd_repeat = cmd_repeat_q;

`ifdef KEY_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((|drop_vec) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
